// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// vector-unit handoff with a bounded wait, plus a saturating stall counter.
module hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int VPU_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_en,
    input  logic             id_rs2_en,
    input  logic             id_is_vec,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_rd_we,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             br_taken,
    input  logic             vpu_done,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             vpu_start,
    output logic             vpu_err,
    output logic [1:0]       state,
    output logic [15:0]      stall_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_VEC_WAIT = 2'd2;
    localparam logic [7:0] TMO_LIMIT   = 8'(VPU_TIMEOUT);
    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

    logic [1:0]  state_q, state_d;
    logic        vpu_err_q, vpu_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        load_haz_s;
    logic        stall_if_s, stall_id_s, bubble_ex_s, flush_if_id_s, vpu_start_s;

    assign load_haz_s = id_valid & ex_valid & ex_is_load & ex_rd_we & (ex_rd != REG_ZERO) &
                        ((id_rs1_en & (id_rs1 == ex_rd)) | (id_rs2_en & (id_rs2 == ex_rd)));

    // Next-state, Mealy control outputs and counter updates
    always_comb begin
        state_d       = state_q;
        vpu_err_d     = vpu_err_q;
        tmo_cnt_d     = tmo_cnt_q;
        stall_if_s    = 1'b0;
        stall_id_s    = 1'b0;
        bubble_ex_s   = 1'b0;
        flush_if_id_s = 1'b0;
        vpu_start_s   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (br_taken) begin
                    flush_if_id_s = 1'b1;
                    bubble_ex_s   = 1'b1;
                    state_d       = ST_FLUSH;
                end else if (load_haz_s) begin
                    stall_if_s  = 1'b1;
                    stall_id_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                end else if (id_valid && id_is_vec) begin
                    vpu_start_s = 1'b1;
                    stall_if_s  = 1'b1;
                    stall_id_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                    tmo_cnt_d   = 8'd0;
                    state_d     = ST_VEC_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_if_id_s = 1'b1;
                bubble_ex_s   = 1'b1;
                state_d       = ST_RUN;
            end
            ST_VEC_WAIT: begin
                // Done wins over a coincident timeout; EX holds a bubble so br_taken is moot
                if (vpu_done) begin
                    state_d = ST_RUN;
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    vpu_err_d = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    stall_if_s  = 1'b1;
                    stall_id_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                    tmo_cnt_d   = tmo_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (stall_id_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            vpu_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
            tmo_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            vpu_err_q   <= vpu_err_d;
            stall_cnt_q <= stall_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign stall_if    = rst_n & stall_if_s;
    assign stall_id    = rst_n & stall_id_s;
    assign bubble_ex   = rst_n & bubble_ex_s;
    assign flush_if_id = rst_n & flush_if_id_s;
    assign vpu_start   = rst_n & vpu_start_s;
    assign vpu_err     = vpu_err_q;
    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a short-timeout
// instance sharing the same stimulus.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_rs1_en, id_rs2_en, id_is_vec;
    logic [3:0] id_rs1, id_rs2, ex_rd;
    logic       ex_valid, ex_is_load, ex_rd_we, br_taken, vpu_done;

    logic        a_stall_if, a_stall_id, a_bubble_ex, a_flush, a_vstart, a_err;
    logic [1:0]  a_state;
    logic [15:0] a_cnt;
    logic        t_stall_if, t_stall_id, t_bubble_ex, t_flush, t_vstart, t_err;
    logic [1:0]  t_state;
    logic [15:0] t_cnt;
    logic [4:0]  a_ctrl, t_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    assign a_ctrl = {a_stall_if, a_stall_id, a_bubble_ex, a_flush, a_vstart};
    assign t_ctrl = {t_stall_if, t_stall_id, t_bubble_ex, t_flush, t_vstart};

    hazard_ctrl #(.REG_W(4), .VPU_TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_is_vec(id_is_vec),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd_we(ex_rd_we), .ex_rd(ex_rd),
        .br_taken(br_taken), .vpu_done(vpu_done), .stall_if(a_stall_if), .stall_id(a_stall_id),
        .bubble_ex(a_bubble_ex), .flush_if_id(a_flush), .vpu_start(a_vstart),
        .vpu_err(a_err), .state(a_state), .stall_cnt(a_cnt)
    );

    hazard_ctrl #(.REG_W(4), .VPU_TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_is_vec(id_is_vec),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd_we(ex_rd_we), .ex_rd(ex_rd),
        .br_taken(br_taken), .vpu_done(vpu_done), .stall_if(t_stall_if), .stall_id(t_stall_id),
        .bubble_ex(t_bubble_ex), .flush_if_id(t_flush), .vpu_start(t_vstart),
        .vpu_err(t_err), .state(t_state), .stall_cnt(t_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 1'b0; id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_en = 1'b0; id_rs2_en = 1'b0;
        id_is_vec = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd_we = 1'b0; ex_rd = 4'd0;
        br_taken = 1'b0; vpu_done = 1'b0;
    endtask

    task automatic set_load_haz();
        id_valid = 1'b1; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_we = 1'b1;
        ex_rd = 4'd3; id_rs2 = 4'd3; id_rs2_en = 1'b1;
    endtask

    initial begin
        // Reset with hostile inputs: outputs must stay quiet
        clear_inputs();
        rst_n = 1'b0; id_valid = 1'b1; id_is_vec = 1'b1; br_taken = 1'b1;
        step(); step();
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        half();
        chk("rst_ctrl", 32'(a_ctrl), 32'd0);
        step(); rst_n = 1'b1; clear_inputs();
        half();
        chk("idle_ctrl", 32'(a_ctrl), 32'd0);

        // Load-use on rs2
        step(); set_load_haz();
        half();
        chk("lu_ctrl", 32'(a_ctrl), 32'b11100);
        step();
        chk("lu_state", 32'(a_state), 32'd0);
        chk("lu_cnt", 32'(a_cnt), 32'd1);
        ex_valid = 1'b0;
        half();
        chk("lu_clear_ctrl", 32'(a_ctrl), 32'd0);
        step();
        chk("lu_clear_cnt", 32'(a_cnt), 32'd1);
        ex_valid = 1'b1; ex_rd = 4'd0; id_rs2 = 4'd0;
        half();
        chk("lu_rd0_ctrl", 32'(a_ctrl), 32'd0);
        step();
        chk("lu_rd0_cnt", 32'(a_cnt), 32'd1);
        // Load-use on rs1, then same specifiers with enable low
        ex_rd = 4'd5; id_rs1 = 4'd5; id_rs1_en = 1'b1; id_rs2_en = 1'b0;
        half();
        chk("lu_rs1_ctrl", 32'(a_ctrl), 32'b11100);
        step();
        chk("lu_rs1_cnt", 32'(a_cnt), 32'd2);
        id_rs1_en = 1'b0;
        half();
        chk("lu_en0_ctrl", 32'(a_ctrl), 32'd0);
        step();
        chk("lu_en0_cnt", 32'(a_cnt), 32'd2);

        // Taken branch beats a simultaneous load hazard and vector op
        id_rs1_en = 1'b1; id_is_vec = 1'b1; br_taken = 1'b1;
        half();
        chk("br_c0_ctrl", 32'(a_ctrl), 32'b00110);
        step();
        chk("br_c1_state", 32'(a_state), 32'd1);
        br_taken = 1'b0;
        half();
        chk("br_c1_ctrl", 32'(a_ctrl), 32'b00110);
        step();
        chk("br_c2_state", 32'(a_state), 32'd0);
        chk("br_cnt", 32'(a_cnt), 32'd2);
        clear_inputs();
        half();
        chk("br_after_ctrl", 32'(a_ctrl), 32'd0);

        // Vector op with done on cycle 10
        step(); id_valid = 1'b1; id_is_vec = 1'b1;
        half();
        chk("vec_c0_ctrl", 32'(a_ctrl), 32'b11101);
        step();
        chk("vec_c1_state", 32'(a_state), 32'd2);
        br_taken = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            half();
            chk($sformatf("vec_c%0d_ctrl", c), 32'(a_ctrl), 32'b11100);
            step();
        end
        vpu_done = 1'b1;
        half();
        chk("vec_done_ctrl", 32'(a_ctrl), 32'd0);
        step();
        chk("vec_done_state", 32'(a_state), 32'd0);
        chk("vec_done_cnt", 32'(a_cnt), 32'd12);
        chk("vec_done_err", 32'(a_err), 32'd0);
        clear_inputs(); vpu_done = 1'b1;
        half();
        chk("done_run_ctrl", 32'(a_ctrl), 32'd0);
        step();
        chk("done_run_state", 32'(a_state), 32'd0);
        clear_inputs();

        // Timeout on the short-limit instance
        rst_n = 1'b0;
        step();
        chk("t_rst_err", 32'(t_err), 32'd0);
        chk("t_rst_state", 32'(t_state), 32'd0);
        rst_n = 1'b1; id_valid = 1'b1; id_is_vec = 1'b1;
        half();
        chk("t_launch_ctrl", 32'(t_ctrl), 32'b11101);
        step();
        chk("t_wait_state", 32'(t_state), 32'd2);
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            half();
            chk($sformatf("t_wait%0d_ctrl", c), 32'(t_ctrl), 32'b11100);
            chk($sformatf("t_wait%0d_err", c), 32'(t_err), 32'd0);
            step();
        end
        half();
        chk("t_abort_ctrl", 32'(t_ctrl), 32'd0);
        step();
        chk("t_abort_state", 32'(t_state), 32'd0);
        chk("t_abort_err", 32'(t_err), 32'd1);
        repeat (20) step();
        chk("t_sticky_err", 32'(t_err), 32'd1);
        chk("t_sticky_state", 32'(t_state), 32'd0);
        chk("a_still_wait", 32'(a_state), 32'd2);

        // Reset while the default instance is in VEC_WAIT
        rst_n = 1'b0; id_valid = 1'b1; id_is_vec = 1'b1; br_taken = 1'b1;
        half();
        chk("midrst_ctrl", 32'(a_ctrl), 32'd0);
        step();
        chk("midrst_state", 32'(a_state), 32'd0);
        chk("midrst_cnt", 32'(a_cnt), 32'd0);
        chk("midrst_err", 32'(a_err), 32'd0);
        chk("midrst_t_err", 32'(t_err), 32'd0);
        rst_n = 1'b1; clear_inputs();

        // Done and timeout in the same cycle counts as done
        id_valid = 1'b1; id_is_vec = 1'b1;
        step(); clear_inputs();
        repeat (4) step();
        vpu_done = 1'b1;
        half();
        chk("t_tie_ctrl", 32'(t_ctrl), 32'd0);
        step();
        chk("t_tie_state", 32'(t_state), 32'd0);
        chk("t_tie_err", 32'(t_err), 32'd0);
        clear_inputs();

        // Stall counter saturation
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; set_load_haz();
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(a_cnt), 32'hFFFE);
        step();
        chk("sat_ffff", 32'(a_cnt), 32'hFFFF);
        half();
        chk("sat_ctrl", 32'(a_ctrl), 32'b11100);
        step();
        chk("sat_hold", 32'(a_cnt), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_W, default 4: register-specifier width; register 0 is hardwired zero and never causes a hazard.
REQ-002 Parameter VPU_TIMEOUT, default 255: maximum VEC_WAIT cycles before an abort, legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 id_rs1, id_rs2  in  REG_W each  ID source specifiers.
REQ-007 id_rs1_en, id_rs2_en  in  1 each  source actually read.
REQ-008 id_is_vec  in  1  ID instruction is a vector operation that must be handed to the VPU.
REQ-009 ex_valid, ex_is_load, ex_rd_we  in  1 each  EX-stage instruction status.
REQ-010 ex_rd  in  REG_W  EX destination specifier.
REQ-011 br_taken  in  1  EX resolved a taken branch this cycle.
REQ-012 vpu_done  in  1  VPU completion pulse.
REQ-013 stall_if, stall_id  out  1 each  hold PC and IF/ID register.
REQ-014 bubble_ex  out  1  load a NOP into ID/EX.
REQ-015 flush_if_id  out  1  invalidate IF/ID register.
REQ-016 vpu_start  out  1  single-cycle VPU launch strobe.
REQ-017 vpu_err  out  1  sticky timeout flag.
REQ-018 state  out  2  FSM state: RUN=0, FLUSH=1, VEC_WAIT=2.
REQ-019 stall_cnt  out  16  saturating count of cycles with stall_id=1.

Function
REQ-020 Control outputs stall_if, stall_id, bubble_ex, flush_if_id and vpu_start shall be combinational (Mealy) functions of state and current inputs; state, vpu_err, stall_cnt and the timeout counter shall be registered.
REQ-021 load_haz = id_valid & ex_valid & ex_is_load & ex_rd_we & (ex_rd!=0) & ((id_rs1_en & id_rs1==ex_rd) | (id_rs2_en & id_rs2==ex_rd)).
REQ-022 RUN, br_taken=1: flush_if_id=1, bubble_ex=1, no stall, vpu_start=0; next state FLUSH. br_taken has priority over load_haz and id_is_vec.
REQ-023 RUN, br_taken=0, load_haz=1: stall_if=stall_id=bubble_ex=1 for that cycle only; remain RUN; vpu_start=0 even if id_is_vec.
REQ-024 RUN, br_taken=0, load_haz=0, id_valid&id_is_vec: vpu_start=1, bubble_ex=1, stall_if=stall_id=1; next state VEC_WAIT; timeout counter cleared to 0.
REQ-025 FLUSH: flush_if_id=1, bubble_ex=1 for exactly one cycle, all other control outputs 0, inputs ignored; next state RUN (two-cycle taken-branch penalty).
REQ-026 VEC_WAIT, vpu_done=0: stall_if=stall_id=bubble_ex=1; timeout counter increments; br_taken ignored because EX holds a bubble.
REQ-027 VEC_WAIT, vpu_done=1: all control outputs 0 in that cycle; next state RUN; vpu_err unchanged.
REQ-028 VEC_WAIT, counter==VPU_TIMEOUT with vpu_done=0: vpu_err set to 1, stalls deasserted that cycle, next state RUN; vpu_done and timeout in the same cycle count as done, with no error.
REQ-029 vpu_err shall stay 1 until reset; vpu_done seen outside VEC_WAIT shall be ignored.
REQ-030 stall_cnt shall increment each cycle stall_id=1 and saturate at 16'hFFFF with no wrap.
REQ-031 The state encoding value 3 is illegal; if it is ever reached, the next state shall be RUN with all control outputs 0.

Reset
REQ-032 With rst_n=0 at posedge clk: state=RUN, vpu_err=0, stall_cnt=0, timeout counter=0.
REQ-033 While rst_n=0, all combinational control outputs shall be 0 regardless of inputs.
REQ-034 Reset asserted during VEC_WAIT or FLUSH shall abort to RUN on that edge, with no vpu_err set.

Verification
REQ-035 Load-use: ex_is_load=1, ex_rd=3, ex_rd_we=1, id_rs2=3, id_rs2_en=1 -> one cycle with stall_if/stall_id/bubble_ex=1, stall_cnt increments by 1; with ex_rd=0 instead -> no stall.
REQ-036 Taken branch plus simultaneous load_haz: br_taken=1 -> cycle 0 flush_if_id=1, stall_id=0; cycle 1 state=FLUSH with flush_if_id=1; cycle 2 state=RUN.
REQ-037 Vector op: id_is_vec=1 -> vpu_start exactly one cycle; stall for 10 cycles; vpu_done on cycle 10 -> stalls drop that cycle, state=RUN next cycle, stall_cnt=10.
REQ-038 Timeout: VPU_TIMEOUT=4 and no vpu_done -> vpu_err=1 after the 5th VEC_WAIT cycle, state=RUN, vpu_err still 1 after 20 further cycles.
REQ-039 Reset mid-VEC_WAIT: rst_n=0 for one edge -> state=0, stall_cnt=0, vpu_err=0, all outputs 0.
REQ-040 Saturation: stall_cnt driven to 16'hFFFF, then a further stall cycle -> stall_cnt remains 16'hFFFF.
